// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: requester id, response tag, default read latency.
// No logic; types only.
// No backpressure applies to type definitions.
package mem_arb_pkg;

  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

  typedef struct packed {
    logic valid;
    req_e owner;
    logic is_store;
  } tag_t;

  localparam int RD_LAT_DEF = 1;

endpackage

// File: rtl/rsp_tag_pipe.sv
// Response tag shift register; a tag pushed at edge N appears on out_tag during cycle N+DEPTH.
// Latency DEPTH cycles, one tag per cycle, synchronous clear drops every tag in flight.
// No backpressure: the tag advances every cycle and the consumer must sink it on exit.
module rsp_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic clr,
  input  tag_t push_tag,
  output tag_t out_tag
);

  tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= push_tag;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign out_tag = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF and LSU; MEM_ARB_RR_EN selects round-robin, else LSU-priority.
// Latency: port driven the cycle after acceptance, response 1+RD_LAT cycles after acceptance.
// Backpressure only on requests (ready = grant); responses cannot be stalled.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int AW     = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [AW-1:0] if_addr,
  output logic          if_rsp_valid,
  output logic [31:0]   if_rsp_data,
  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic [AW-1:0] lsu_addr,
  input  logic          lsu_we,
  input  logic [31:0]   lsu_wdata,
  input  logic [3:0]    lsu_be,
  output logic          lsu_rsp_valid,
  output logic [31:0]   lsu_rsp_data,
  output logic [AW-1:0] DataAdr,
  output logic [31:0]   WriteData,
  output logic          MemWrite,
  output logic [3:0]    mem_be,
  output logic          mem_re,
  input  logic [31:0]   mem_rdata
);

  logic if_gnt, lsu_gnt, lsu_wins;
  tag_t push_tag, out_tag;

`ifdef MEM_ARB_RR_EN
  req_e last_grant;

  always_ff @(posedge clk) begin
    if (reset)        last_grant <= REQ_IF;
    else if (if_gnt)  last_grant <= REQ_IF;
    else if (lsu_gnt) last_grant <= REQ_LSU;
  end

  // Ties go to whoever was not served last; reset state makes the first tie LSU's.
  assign lsu_wins = (last_grant == REQ_IF);
`else
  assign lsu_wins = 1'b1;
`endif

  always_comb begin
    if_gnt  = 1'b0;
    lsu_gnt = 1'b0;
    if (en && !reset) begin
      if (lsu_req_valid && (!if_req_valid || lsu_wins)) lsu_gnt = 1'b1;
      else if (if_req_valid)                            if_gnt  = 1'b1;
    end
  end

  assign if_req_ready  = if_gnt;
  assign lsu_req_ready = lsu_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      DataAdr   <= '0;
      WriteData <= '0;
      MemWrite  <= 1'b0;
      mem_re    <= 1'b0;
      mem_be    <= 4'h0;
    end else begin
      MemWrite <= 1'b0;
      mem_re   <= 1'b0;
      mem_be   <= 4'h0;
      if (lsu_gnt) begin
        DataAdr <= lsu_addr;
        if (lsu_we) begin
          MemWrite  <= 1'b1;
          WriteData <= lsu_wdata;
          mem_be    <= lsu_be;
        end else begin
          mem_re <= 1'b1;
          mem_be <= 4'hF;
        end
      end else if (if_gnt) begin
        DataAdr <= if_addr;
        mem_re  <= 1'b1;
        mem_be  <= 4'hF;
      end
    end
  end

  always_comb begin
    push_tag          = '0;
    push_tag.valid    = if_gnt | lsu_gnt;
    push_tag.owner    = lsu_gnt ? REQ_LSU : REQ_IF;
    push_tag.is_store = lsu_gnt & lsu_we;
  end

  // One stage for the port register plus RD_LAT for the memory itself.
  rsp_tag_pipe #(.DEPTH(1 + RD_LAT)) u_tag_pipe (
    .clk      (clk),
    .clr      (reset),
    .push_tag (push_tag),
    .out_tag  (out_tag)
  );

  assign if_rsp_valid  = out_tag.valid && (out_tag.owner == REQ_IF);
  assign lsu_rsp_valid = out_tag.valid && (out_tag.owner == REQ_LSU);
  assign if_rsp_data   = mem_rdata;
  assign lsu_rsp_data  = out_tag.is_store ? 32'h0 : mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter: RD_LAT=1 instance for the table, RD_LAT=3 for pipelined fetch.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif
  localparam logic O = 1'b1;
  localparam logic N = 1'b0;
  localparam logic [31:0] Z32 = 32'h0;
  localparam logic [31:0] A  = 32'h0000_0100;
  localparam logic [31:0] B  = 32'h0000_0104;
  localparam logic [31:0] L  = 32'h0000_0300;
  localparam logic [31:0] S  = 32'h0000_0200;
  localparam logic [31:0] D1 = 32'hDEAD_BEEF;
  localparam logic [31:0] D2 = 32'hCAFE_F00D;
  localparam logic [31:0] D3 = 32'h0BAD_F00D;
  localparam logic [31:0] W  = 32'h1234_5678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, en, iv, lv, lwe;
  logic [31:0] ia, la, lwd, rd1;
  logic [3:0] lbe;
  logic irdy, lrdy, irsp, lrsp, mw, re;
  logic [31:0] idat, ldat, adr, wd;
  logic [3:0] be;

  logic en3, iv3, lv3, lwe3;
  logic [31:0] ia3, la3, lwd3, rd3;
  logic [3:0] lbe3;
  logic irdy3, lrdy3, irsp3, lrsp3, mw3, re3;
  logic [31:0] idat3, ldat3, adr3, wd3;
  logic [3:0] be3;

  mem_port_arbiter #(.RD_LAT(1), .AW(32)) u_dut (
    .clk(clk), .reset(reset), .en(en),
    .if_req_valid(iv), .if_req_ready(irdy), .if_addr(ia),
    .if_rsp_valid(irsp), .if_rsp_data(idat),
    .lsu_req_valid(lv), .lsu_req_ready(lrdy), .lsu_addr(la), .lsu_we(lwe),
    .lsu_wdata(lwd), .lsu_be(lbe), .lsu_rsp_valid(lrsp), .lsu_rsp_data(ldat),
    .DataAdr(adr), .WriteData(wd), .MemWrite(mw), .mem_be(be), .mem_re(re),
    .mem_rdata(rd1)
  );

  mem_port_arbiter #(.RD_LAT(3), .AW(32)) u_dut3 (
    .clk(clk), .reset(reset), .en(en3),
    .if_req_valid(iv3), .if_req_ready(irdy3), .if_addr(ia3),
    .if_rsp_valid(irsp3), .if_rsp_data(idat3),
    .lsu_req_valid(lv3), .lsu_req_ready(lrdy3), .lsu_addr(la3), .lsu_we(lwe3),
    .lsu_wdata(lwd3), .lsu_be(lbe3), .lsu_rsp_valid(lrsp3), .lsu_rsp_data(ldat3),
    .DataAdr(adr3), .WriteData(wd3), .MemWrite(mw3), .mem_be(be3), .mem_re(re3),
    .mem_rdata(rd3)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      A:       return D1;
      B:       return D2;
      L:       return D3;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Memory model: address sampled at the edge, data RD_LAT cycles later.
  logic [31:0] p3 [3];
  always @(posedge clk) begin
    rd1   <= mem_rd(adr);
    p3[0] <= mem_rd(adr3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rd3 = p3[2];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic        en, iv;
    logic [31:0] ia;
    logic        lv;
    logic [31:0] la;
    logic        lwe;
    logic [31:0] lwd;
    logic [3:0]  lbe;
    logic        irdy, lrdy, re, mw;
    logic [3:0]  be;
    logic [31:0] adr, wd;
    logic        irsp, lrsp;
    logic [31:0] rdat;
  } vec_t;

  vec_t tv [15];

  task automatic drive(input vec_t v);
    en = v.en; iv = v.iv; ia = v.ia; lv = v.lv; la = v.la;
    lwe = v.lwe; lwd = v.lwd; lbe = v.lbe;
  endtask

  task automatic step_idle();
    @(posedge clk); #1;
    iv = N; lv = N; en = O;
    @(negedge clk);
  endtask

  initial begin
    //        en iv ia   lv la   we lwd  lbe    irdy lrdy re mw be    adr        wd   irsp lrsp rdat
    tv[0]  = '{O, O, A,  N, Z32, N, Z32, 4'h0,  O,   N,   N, N, 4'h0, Z32,       Z32, N,   N,   Z32};
    tv[1]  = '{O, O, B,  O, L,   N, Z32, 4'h0,  N,   O,   O, N, 4'hF, A,         Z32, N,   N,   Z32};
    tv[2]  = '{O, O, B,  O, L,   N, Z32, 4'h0,  RR,  !RR, O, N, 4'hF, L,         Z32, O,   N,   D1};
    tv[3]  = '{O, O, B,  O, L,   N, Z32, 4'h0,  N,   O,   O, N, 4'hF, RR ? B : L, Z32, N,  O,   D3};
    tv[4]  = '{O, O, B,  O, L,   N, Z32, 4'h0,  RR,  !RR, O, N, 4'hF, L,         Z32, RR,  !RR, RR ? D2 : D3};
    tv[5]  = '{O, O, B,  O, L,   N, Z32, 4'h0,  N,   O,   O, N, 4'hF, RR ? B : L, Z32, N,  O,   D3};
    tv[6]  = '{O, O, B,  O, L,   N, Z32, 4'h0,  RR,  !RR, O, N, 4'hF, L,         Z32, RR,  !RR, RR ? D2 : D3};
    tv[7]  = '{O, N, Z32, O, S,  O, W,   4'h3,  N,   O,   O, N, 4'hF, RR ? B : L, Z32, N,  O,   D3};
    tv[8]  = '{O, N, Z32, N, Z32, N, Z32, 4'h0, N,   N,   N, O, 4'h3, S,         W,   RR,  !RR, RR ? D2 : D3};
    tv[9]  = '{O, N, Z32, N, Z32, N, Z32, 4'h0, N,   N,   N, N, 4'h0, S,         W,   N,   O,   Z32};
    tv[10] = '{O, N, Z32, O, L,  N, Z32, 4'h0,  N,   O,   N, N, 4'h0, S,         W,   N,   N,   Z32};
    tv[11] = '{N, O, B,  O, L,   N, Z32, 4'h0,  N,   N,   O, N, 4'hF, L,         W,   N,   N,   Z32};
    tv[12] = '{N, O, B,  O, L,   N, Z32, 4'h0,  N,   N,   N, N, 4'h0, L,         W,   N,   O,   D3};
    tv[13] = '{N, O, B,  O, L,   N, Z32, 4'h0,  N,   N,   N, N, 4'h0, L,         W,   N,   N,   Z32};
    tv[14] = '{O, N, Z32, N, Z32, N, Z32, 4'h0, N,   N,   N, N, 4'h0, L,         W,   N,   N,   Z32};

    reset = O; en = O; iv = O; ia = A; lv = O; la = L; lwe = N; lwd = Z32; lbe = 4'h0;
    en3 = O; iv3 = O; ia3 = Z32; lv3 = N; la3 = Z32; lwe3 = N; lwd3 = Z32; lbe3 = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.if_ready", {31'b0, irdy}, 32'h0);
    chk("rst.lsu_ready", {31'b0, lrdy}, 32'h0);
    chk("rst.if_ready_lat3", {31'b0, irdy3}, 32'h0);
    chk("rst.port", {26'b0, re, mw, be}, 32'h0);
    chk("rst.DataAdr", adr, Z32);
    chk("rst.WriteData", wd, Z32);
    chk("rst.rsp", {30'b0, irsp, lrsp}, 32'h0);

    @(posedge clk); #1;
    reset = N; iv = N; lv = N; iv3 = N;

    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      drive(tv[i]);
      @(negedge clk);
      chk($sformatf("v%0d.if_ready", i), {31'b0, irdy}, {31'b0, tv[i].irdy});
      chk($sformatf("v%0d.lsu_ready", i), {31'b0, lrdy}, {31'b0, tv[i].lrdy});
      chk($sformatf("v%0d.re_we_be", i), {26'b0, re, mw, be}, {26'b0, tv[i].re, tv[i].mw, tv[i].be});
      chk($sformatf("v%0d.DataAdr", i), adr, tv[i].adr);
      chk($sformatf("v%0d.WriteData", i), wd, tv[i].wd);
      chk($sformatf("v%0d.if_rsp_valid", i), {31'b0, irsp}, {31'b0, tv[i].irsp});
      chk($sformatf("v%0d.lsu_rsp_valid", i), {31'b0, lrsp}, {31'b0, tv[i].lrsp});
      if (tv[i].irsp) chk($sformatf("v%0d.if_rsp_data", i), idat, tv[i].rdat);
      if (tv[i].lrsp) chk($sformatf("v%0d.lsu_rsp_data", i), ldat, tv[i].rdat);
    end

    // Reset the cycle after an IF acceptance: its response must never appear.
    @(posedge clk); #1;
    en = O; iv = O; ia = A; lv = N;
    @(negedge clk);
    chk("mr.accept", {31'b0, irdy}, 32'h1);
    @(posedge clk); #1;
    reset = O;
    @(negedge clk);
    chk("mr.ready_in_reset", {31'b0, irdy}, 32'h0);
    chk("mr.port_before_reset", {26'b0, re, mw, be}, {26'b0, O, N, 4'hF});
    @(posedge clk); #1;
    reset = N; iv = O; ia = A; lv = O; la = L; lwe = N;
    @(negedge clk);
    chk("mr.if_rsp_dropped", {31'b0, irsp}, 32'h0);
    chk("mr.port_reset", {26'b0, re, mw, be}, 32'h0);
    chk("mr.DataAdr_reset", adr, Z32);
    chk("mr.WriteData_reset", wd, Z32);
    chk("mr.first_tie_lsu", {30'b0, irdy, lrdy}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr.second_tie", {30'b0, irdy, lrdy}, {30'b0, RR, !RR});
    chk("mr.if_rsp_still_dropped", {31'b0, irsp}, 32'h0);
    chk("mr.port_load", adr, L);
    @(posedge clk); #1;
    iv = N; lv = N;
    @(negedge clk);
    chk("mr.lsu_rsp", {30'b0, irsp, lrsp}, 32'h1);
    chk("mr.lsu_rsp_data", ldat, D3);
    chk("mr.port_second", adr, RR ? A : L);
    step_idle();
    chk("mr.second_rsp", {30'b0, irsp, lrsp}, {30'b0, RR, !RR});
    chk("mr.second_rsp_data", RR ? idat : ldat, RR ? D1 : D3);

    // RD_LAT=3: three back-to-back fetches, responses in cycles 4..6 after the first.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      iv3 = O; ia3 = 32'(4 * k);
      @(negedge clk);
      chk($sformatf("l3.ready%0d", k), {31'b0, irdy3}, 32'h1);
      chk($sformatf("l3.no_rsp%0d", k), {31'b0, irsp3}, 32'h0);
      if (k == 2) chk("l3.port_adr", adr3, 32'h4);
    end
    for (int j = 3; j < 8; j++) begin
      @(posedge clk); #1;
      iv3 = N;
      @(negedge clk);
      chk($sformatf("l3.rsp_valid_c%0d", j), {31'b0, irsp3}, {31'b0, (j >= 4 && j <= 6)});
      chk($sformatf("l3.lsu_rsp_c%0d", j), {31'b0, lrsp3}, 32'h0);
      if (j >= 4 && j <= 6)
        chk($sformatf("l3.rsp_data_c%0d", j), idat3, 32'(4 * (j - 4)) ^ 32'hA5A5_0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
